// File: rtl/bus_arb_if.sv
// Shared-bus signal bundle: per-source request/lock/data in, grant and
// registered broadcast bus out. The arbiter uses the master view, sources
// (or a bench) use the slave view.
interface bus_arb_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8,
  parameter int CNT_W = 8
);
  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]       src_req;
  logic [NSRC-1:0]       src_lock;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_gnt;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [IDX_W-1:0]      bus_owner;
  logic                  conflict;
  logic [CNT_W-1:0]      conflict_cnt;
  logic                  lock_err;

  modport master (
    input  src_req, src_lock, src_data,
    output src_gnt, bus_out, bus_valid, bus_owner, conflict, conflict_cnt, lock_err
  );

  modport slave (
    output src_req, src_lock, src_data,
    input  src_gnt, bus_out, bus_valid, bus_owner, conflict, conflict_cnt, lock_err
  );
endinterface

// File: rtl/bus_arb.sv
// Registered shared data bus with round-robin arbitration, bounded locked
// transfers and detection of ungranted sources driving non-zero data.
module bus_arb #(
  parameter int WIDTH    = 16,
  parameter int NSRC     = 8,
  parameter int LOCK_MAX = 4,
  parameter int CNT_W    = 8
) (
  input logic      clk,
  input logic      reset,
  bus_arb_if.master bus
);
  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int LCW   = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN, LOCK} state_t;

  state_t            state_q;
  logic [NSRC-1:0]   gnt_q;
  logic [IDX_W-1:0]  own_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [LCW-1:0]    lock_cnt_q;
  logic [WIDTH-1:0]  bus_out_q;
  logic              bus_valid_q;
  logic [IDX_W-1:0]  bus_owner_q;
  logic              conflict_q;
  logic [CNT_W-1:0]  conflict_cnt_q;
  logic              lock_err_q;

  logic              own_wants;
  logic              hold;
  logic              force_brk;
  logic [NSRC-1:0]   cand;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic              conflict_d;

  // Lock bookkeeping and round-robin search from the pointer; a timed-out
  // owner is masked out of its own re-arbitration.
  always_comb begin
    int idx;
    idx       = 0;
    own_wants = bus.src_req[own_q] & bus.src_lock[own_q];
    hold      = (state_q == LOCK) && own_wants && (lock_cnt_q < LCW'(LOCK_MAX));
    force_brk = (state_q == LOCK) && own_wants && (lock_cnt_q >= LCW'(LOCK_MAX));
    cand      = bus.src_req;
    if (force_brk) cand[own_q] = 1'b0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  // Conflict: while the bus is granted, any other source driving non-zero.
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (i != int'(own_q) && bus.src_data[i*WIDTH +: WIDTH] != '0) conflict_d = 1'b1;
    end
    conflict_d = conflict_d & (|gnt_q);
  end

  // Arbiter FSM plus registered bus datapath and conflict statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      own_q          <= '0;
      ptr_q          <= '0;
      lock_cnt_q     <= '0;
      bus_out_q      <= '0;
      bus_valid_q    <= 1'b0;
      bus_owner_q    <= '0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
      lock_err_q     <= 1'b0;
    end else begin
      lock_err_q <= force_brk;
      if (hold) begin
        lock_cnt_q <= lock_cnt_q + 1'b1;
      end else if (found) begin
        gnt_q <= NSRC'(1) << win;
        own_q <= win;
        ptr_q <= (win == IDX_W'(NSRC - 1)) ? '0 : win + IDX_W'(1);
        if (bus.src_lock[win]) begin
          state_q    <= LOCK;
          lock_cnt_q <= LCW'(1);
        end else begin
          state_q    <= OWN;
          lock_cnt_q <= '0;
        end
      end else begin
        state_q    <= IDLE;
        gnt_q      <= '0;
        lock_cnt_q <= '0;
      end

      // Only the granted source's word reaches the bus; idle reads zero.
      bus_valid_q <= |gnt_q;
      if (|gnt_q) begin
        bus_out_q   <= bus.src_data[int'(own_q)*WIDTH +: WIDTH];
        bus_owner_q <= own_q;
      end else begin
        bus_out_q <= '0;
      end

      conflict_q <= conflict_d;
      if (conflict_d && conflict_cnt_q != {CNT_W{1'b1}})
        conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  assign bus.src_gnt      = gnt_q;
  assign bus.bus_out      = bus_out_q;
  assign bus.bus_valid    = bus_valid_q;
  assign bus.bus_owner    = bus_owner_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.lock_err     = lock_err_q;
endmodule
